// File: rtl/nios_key_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
package nios_key_pkg;

    // 20 ms at a 50 MHz system clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Normalised key level values (after polarity correction).
    localparam logic KEY_PRESSED  = 1'b1;
    localparam logic KEY_RELEASED = 1'b0;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int calc_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nios_key_debounce_chan.sv
// One key channel: two-flop synchroniser, stability counter, debounced
// level and single-cycle press/release pulses.
module nios_key_debounce_chan
    import nios_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CNT_W = calc_cnt_w(DEBOUNCE_CYCLES);

    // Pin value seen when the key is not pressed; also the XOR mask that
    // turns a pin sample into a 1 = pressed level.
    localparam logic RELEASED_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    // A terminal count below one cycle of filtering makes no sense.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $fatal(1, "nios_key_debounce_chan: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_count;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic             w_sample;
    logic             w_differ;
    logic             w_terminal;

    // Synchroniser; both flops reset to the released pin value so leaving
    // reset never looks like a press edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RELEASED_PIN;
            r_sync2 <= RELEASED_PIN;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity and decide whether a pending change is accepted now.
    always_comb begin
        w_sample   = r_sync2 ^ RELEASED_PIN;
        w_differ   = 1'b0;
        w_terminal = 1'b0;
        if (w_sample != r_level) begin
            w_differ   = 1'b1;
            w_terminal = (r_count == CNT_TERMINAL);
        end
    end

    // Stability counter, accepted level and pulses; any return to the
    // current level clears the count so only an unbroken run is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_level   <= KEY_RELEASED;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_differ) begin
                r_count <= '0;
            end else if (w_terminal) begin
                r_level   <= w_sample;
                r_count   <= '0;
                r_press   <= w_sample;
                r_release <= ~w_sample;
            end else begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

// File: rtl/nios_key_debounce.sv
// Push-button conditioning for the key PIO: one independent debounce
// channel per key, no shared state between channels.
module nios_key_debounce
    import nios_key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        nios_key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[gi]),
            .key_level   (key_level[gi]),
            .key_press   (key_press[gi]),
            .key_release (key_release[gi])
        );
    end

endmodule

// File: tb/tb_nios_key_debounce.sv
// Directed bench for nios_key_debounce with an 8-cycle debounce window.
module tb_nios_key_debounce;

    localparam int NK = 4;
    localparam int DC = 8;

    logic          clk;
    logic          reset_n;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    int n_total;
    int n_bad;

    nios_key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Step n cycles expecting a steady level and no pulses on any key.
    task automatic run_quiet(input string tag, input int n, input logic [NK-1:0] lvl);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk(tag, {20'h0, key_level, key_press, key_release}, {20'h0, lvl, 4'h0, 4'h0});
        end
    endtask

    task automatic chk_outs(input string tag, input logic [NK-1:0] lvl,
                            input logic [NK-1:0] prs, input logic [NK-1:0] rel);
        chk({tag, ".level"},   {28'h0, key_level},   {28'h0, lvl});
        chk({tag, ".press"},   {28'h0, key_press},   {28'h0, prs});
        chk({tag, ".release"}, {28'h0, key_release}, {28'h0, rel});
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        key_raw = 4'hF;

        // Reset state, then 50 quiet cycles with all keys released.
        step(3);
        chk_outs("reset", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        run_quiet("rst_quiet", 50, 4'h0);

        // Press key 0: nothing through edge k+8, level and pulse at k+9.
        key_raw = 4'hE;
        run_quiet("k0_wait", 9, 4'h0);
        step(1);
        chk_outs("k0_press", 4'h1, 4'h1, 4'h0);
        step(1);
        chk_outs("k0_after", 4'h1, 4'h0, 4'h0);

        // Bounce train on key 1: low 5, high 2, low 3, high 1, then low.
        key_raw = 4'hC;
        run_quiet("b_low5", 5, 4'h1);
        key_raw = 4'hE;
        run_quiet("b_high2", 2, 4'h1);
        key_raw = 4'hC;
        run_quiet("b_low3", 3, 4'h1);
        key_raw = 4'hE;
        run_quiet("b_high1", 1, 4'h1);
        key_raw = 4'hC;
        run_quiet("b_final", 9, 4'h1);
        step(1);
        chk_outs("k1_press", 4'h3, 4'h2, 4'h0);
        step(1);
        chk_outs("k1_after", 4'h3, 4'h0, 4'h0);

        // Release key 0.
        key_raw = 4'hD;
        run_quiet("k0_rel_wait", 9, 4'h3);
        step(1);
        chk_outs("k0_release", 4'h2, 4'h0, 4'h1);
        step(1);
        chk_outs("k0_rel_after", 4'h2, 4'h0, 4'h0);

        // Keys 2 and 3 together.
        key_raw = 4'h1;
        run_quiet("k23_wait", 9, 4'h2);
        step(1);
        chk_outs("k23_press", 4'hE, 4'hC, 4'h0);
        step(1);
        chk_outs("k23_after", 4'hE, 4'h0, 4'h0);

        // 7-cycle release glitch on key 1 is rejected.
        key_raw = 4'h3;
        run_quiet("glitch", 7, 4'hE);
        key_raw = 4'h1;
        run_quiet("glitch_post", 12, 4'hE);

        // Reset with key 0 held.
        reset_n = 1'b0;
        key_raw = 4'hE;
        #1;
        chk_outs("rst_async", 4'h0, 4'h0, 4'h0);
        step(2);
        reset_n = 1'b1;
        run_quiet("rst_mid", 5, 4'h0);
        reset_n = 1'b0;
        #1;
        chk_outs("rst_midcount", 4'h0, 4'h0, 4'h0);
        step(2);
        chk_outs("rst_hold", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        run_quiet("reacc_wait", 9, 4'h0);
        step(1);
        chk_outs("reacc_press", 4'h1, 4'h1, 4'h0);
        step(1);
        chk_outs("reacc_after", 4'h1, 4'h0, 4'h0);
        reset_n = 1'b0;
        #1;
        chk_outs("rst_accepted", 4'h0, 4'h0, 4'h0);
        step(2);
        reset_n = 1'b1;
        run_quiet("reacc2_wait", 9, 4'h0);
        step(1);
        chk_outs("reacc2_press", 4'h1, 4'h1, 4'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_key_debounce.md
Name: nios_key_debounce

Overview:
- Conditions raw push-button inputs from board pins before they reach the key PIO slave's `in_port`.
- Per key, it synchronises the pin, filters bounce with a stability counter, and normalises polarity.
- Outputs: a clean level bus for the PIO, plus single-cycle press/release pulses for interrupt or edge-capture logic.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 1000000: clock cycles a changed input must stay stable before it is accepted (20 ms at 50 MHz). Legal range ≥ 2.
- ACTIVE_LOW, 1: 1 means the pin reads 0 when pressed; 0 means the pin reads 1 when pressed.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- key_raw  input  NUM_KEYS  asynchronous pin inputs.
- key_level  output  NUM_KEYS  debounced level, 1 = pressed; drives the PIO `in_port`.
- key_press  output  NUM_KEYS  one-cycle pulse on an accepted released→pressed change.
- key_release  output  NUM_KEYS  one-cycle pulse on an accepted pressed→released change.

Behaviour:
- Reset: Reset is reset_n, asynchronous, active-low; clock is clk.
  - While reset_n=0: key_level=0, key_press=0, key_release=0, all counters=0.
  - Both sync flops load the "released" pin value (ACTIVE_LOW ? 1 : 0), so there is no spurious press on reset release.
- Synchroniser: two flops per key, sync1 <= key_raw, sync2 <= sync1.
  - Normalised sample n = sync2 XOR ACTIVE_LOW (1 = pressed).
- Counter: CNT_W = clog2(DEBOUNCE_CYCLES), as a localparam. Each rising clk edge, per key:
  - if n == key_level: count <= 0; no pulse.
  - else if count == DEBOUNCE_CYCLES-1: key_level <= n; count <= 0; key_press <= n; key_release <= ~n.
  - else: count <= count+1.
- Pulses: key_press and key_release are registered and deasserted on every edge that does not flip key_level. Width is exactly 1 cycle.
- Latency: raw change sampled at edge k, then held stable.
  - sync2 shows it after edge k+1.
  - key_level and the pulse change at edge k+1+DEBOUNCE_CYCLES.
- Glitch rejection: if n returns to key_level before the terminal count, the counter clears and no output changes.
  - A bounce train is accepted only after its final DEBOUNCE_CYCLES-long stable interval.
- Independence: channels share no state. Simultaneous events on several keys produce simultaneous pulses on the respective bits.
- No counter saturation or wrap: the counter never exceeds DEBOUNCE_CYCLES-1 because it clears on acceptance.
- Reset mid-count: the count is discarded.
  - key_level returns to 0 even if a key is physically held.
  - A held key is re-accepted DEBOUNCE_CYCLES+2 cycles after reset deassertion, with a key_press pulse.
- Elaboration check: DEBOUNCE_CYCLES < 2 triggers a fatal elaboration assertion.

Decomposition:
- Package nios_key_pkg:
  - default DEBOUNCE_CYCLES constant;
  - KEY_PRESSED/KEY_RELEASED level constants;
  - function computing CNT_W.
- Sub-module nios_key_debounce_chan: one key (sync, counter, level, pulses).
  - Top instantiates it NUM_KEYS times in a generate loop.
  - Top contains no other logic.

Test Plan (bench uses DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, NUM_KEYS=4):
- Reset release with key_raw=4'hF: key_level=0 and no pulses for 50 cycles.
- key_raw[0] 1→0 at edge k, then held: key_level=4'h1 and key_press=4'h1 for exactly one cycle at edge k+9; no change at edge k+8.
- Bounce on key 1: low 5 cycles, high 2, low 3, high 1, then low held. key_level[1] rises exactly 10 cycles after the final low sample, with a single press pulse and no earlier output activity.
- Release key 0 after acceptance (raw 0→1, held): key_level[0]=0 and key_release=4'h1 for one cycle at edge k+9.
- Keys 2 and 3 pressed on the same cycle: key_press=4'hC in a single cycle. A glitch of ≤7 cycles on key 1 produces no pulse.
- Hold key 0 pressed, assert reset_n=0 mid-count and again after acceptance: outputs clear immediately. After reset release, key_press[0] pulses at cycle DEBOUNCE_CYCLES+2=10.
